multiplicacion_secuencial: RTL and testbench

Sequential shift-add multiply-accumulate unit computing `producto = multiplicando * multiplicador + sumando` over N-bit unsigned operands. It is the inverse of the combinational `division` block. Feeding it `resultado`, `divisor` and `residuo` from a division rebuilds the original `dividendo`, so the pair can be checked end to end in the same datapath. It uses one operation at a time under a start/done handshake and takes one multiplier bit per clock.

---
 rtl/multiplicacion_secuencial_if.sv | 35 +++
 rtl/multiplicacion_secuencial.sv | 131 +++++++++++++
 tb/tb_multiplicacion_secuencial.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/multiplicacion_secuencial_if.sv
// -----------------------------------------------------------------------------
// multiplicacion_secuencial_if
// Handshake and operand bus for the sequential multiply-accumulate unit.
//   start          request pulse from the requester
//   multiplicando  unsigned multiplicand, N bits
//   multiplicador  unsigned multiplier, N bits
//   sumando        unsigned addend, N bits
//   producto       low N bits of multiplicando*multiplicador+sumando
//   desborde       result did not fit in N bits
//   ocupado        unit busy (CALC or DONE)
//   listo          one-cycle completion pulse
// Modports: master = requester side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface multiplicacion_secuencial_if #(
  parameter int N = 19
);
  logic         start;
  logic [N-1:0] multiplicando;
  logic [N-1:0] multiplicador;
  logic [N-1:0] sumando;
  logic [N-1:0] producto;
  logic         desborde;
  logic         ocupado;
  logic         listo;

  modport master (
    output start, multiplicando, multiplicador, sumando,
    input  producto, desborde, ocupado, listo
  );

  modport slave (
    input  start, multiplicando, multiplicador, sumando,
    output producto, desborde, ocupado, listo
  );
endinterface

// File: rtl/multiplicacion_secuencial.sv
// -----------------------------------------------------------------------------
// multiplicacion_secuencial
// Shift-add multiply-accumulate: producto = multiplicando * multiplicador +
// sumando, unsigned, one multiplier bit per clock. Inverse of the `division`
// block: feeding it resultado/divisor/residuo rebuilds the dividend.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high
//   bus  multiplicacion_secuencial_if.slave (start/operands in, results out)
//
// Configuration macro: MULT_DESBORDE_EN
//   defined   -> 2N+1-bit accumulator, 2N-bit shifted multiplicand,
//                desborde reports results that do not fit in N bits
//   undefined -> N-bit accumulator and multiplicand, desborde tied to 0;
//                producto is identical in both builds
//
// Latency: start sampled at edge k -> listo and new producto after edge k+N,
// ocupado low again after edge k+N+1.
// -----------------------------------------------------------------------------
module multiplicacion_secuencial #(
  parameter int N = 19
) (
  input logic                          clk,
  input logic                          rst,
  multiplicacion_secuencial_if.slave   bus
);

`ifdef MULT_DESBORDE_EN
  localparam int AW = 2 * N + 1;
  localparam int MW = 2 * N;
`else
  // Only the low N bits ever reach producto, and carries never propagate
  // downward, so truncating the datapath leaves producto unchanged.
  localparam int AW = N;
  localparam int MW = N;
`endif
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [MW-1:0] mc;
  logic [N-1:0]  mr;
  logic [CW-1:0] cnt;
  logic [N-1:0]  producto_q;
  logic          desborde_q;
  logic          ocupado_q;
  logic          listo_q;

  logic [AW-1:0] acc_next;
  logic          ovf_next;

  // The result is captured from the value acc takes on the final CALC edge,
  // so the conditional add is computed ahead of the register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    acc_next = acc;
    if (mr[0]) acc_next = acc + AW'(mc);
  end

`ifdef MULT_DESBORDE_EN
  assign ovf_next = |acc_next[AW-1:N];
`else
  assign ovf_next = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so an aborted operation
      // leaves no residue and the reset state is fully defined.
      state      <= IDLE;
      acc        <= '0;
      mc         <= '0;
      mr         <= '0;
      cnt        <= '0;
      producto_q <= '0;
      desborde_q <= 1'b0;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc       <= AW'(bus.sumando);
            mc        <= MW'(bus.multiplicando);
            mr        <= bus.multiplicador;
            cnt       <= '0;
            ocupado_q <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          // Fixed N iterations even for a zero multiplier: constant latency.
          acc <= acc_next;
          mc  <= mc << 1;
          mr  <= mr >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            producto_q <= acc_next[N-1:0];
            desborde_q <= ovf_next;
            listo_q    <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          listo_q   <= 1'b0;
          ocupado_q <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.producto = producto_q;
  assign bus.desborde = desborde_q;
  assign bus.ocupado  = ocupado_q;
  assign bus.listo    = listo_q;

endmodule

// File: tb/tb_multiplicacion_secuencial.sv
// -----------------------------------------------------------------------------
// tb_multiplicacion_secuencial
// Directed-vector bench with a scoreboard: the driver pushes the hand-computed
// result and the cycle at which listo must appear; an independent monitor pops
// and compares on every listo pulse. Overflow expectations follow the
// MULT_DESBORDE_EN build of the design.
// -----------------------------------------------------------------------------
module tb_multiplicacion_secuencial;
  localparam int N = 19;

`ifdef MULT_DESBORDE_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] p;
    logic         d;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_bad;
  exp_t sb[$];
  exp_t e;

  multiplicacion_secuencial_if #(.N(N)) bus ();

  multiplicacion_secuencial #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every listo pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && bus.listo === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_listo", 1, 0);
      end else begin
        e = sb.pop_front();
        check("producto", 64'(bus.producto), 64'(e.p));
        check("desborde", 64'(bus.desborde), 64'(e.d));
        check("latency",  64'(cyc),          64'(e.cyc));
      end
    end
  end

  // Pulse start for one cycle from a negedge; returns the accepting edge.
  task automatic pulse_start(input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [N-1:0] c, output int k);
    bus.multiplicando = a;
    bus.multiplicador = b;
    bus.sumando       = c;
    bus.start         = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < N + 10; i++) begin
      if (bus.ocupado === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check(name, 0, 1);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c, input logic [N-1:0] exp_p,
                        input logic ovf);
    int k;
    exp_t x;
    pulse_start(a, b, c, k);
    x.p   = exp_p;
    x.d   = ovf & OVF_EN;
    x.cyc = k + N;
    sb.push_back(x);
    wait_idle("done_timeout");
    @(negedge clk);
  endtask

  initial begin
    int   k;
    exp_t x;
    cyc               = 0;
    n_vec             = 0;
    n_bad             = 0;
    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.multiplicando = '0;
    bus.multiplicador = '0;
    bus.sumando       = '0;
    repeat (2) @(negedge clk);
    check("rst_producto", 64'(bus.producto), 0);
    check("rst_desborde", 64'(bus.desborde), 0);
    check("rst_ocupado",  64'(bus.ocupado),  0);
    check("rst_listo",    64'(bus.listo),    0);
    rst = 1'b0;
    @(negedge clk);

    // Basic, division-inverse and boundary vectors (operands, expected, ovf).
    run_op(19'd5,      19'd5,      19'd0,      19'd25,     1'b0);
    run_op(19'd6,      19'd6,      19'd1,      19'd37,     1'b0);
    run_op(19'd14285,  19'd7,      19'd5,      19'd100000, 1'b0);
    run_op(19'd156,    19'd789,    19'd372,    19'd123456, 1'b0);
    run_op(19'd524,    19'd1000,   19'd287,    19'd524287, 1'b0);
    run_op(19'd524287, 19'd2,      19'd0,      19'd524286, 1'b1);
    run_op(19'd524287, 19'd524287, 19'd524287, 19'd0,      1'b1);
    run_op(19'd0,      19'd12345,  19'd7,      19'd7,      1'b0);
    run_op(19'd1,      19'd1,      19'd0,      19'd1,      1'b0);

    // Busy rejection: a second start and changed operands mid-CALC are ignored.
    pulse_start(19'd3, 19'd4, 19'd0, k);
    x.p = 19'd12; x.d = 1'b0; x.cyc = k + N;
    sb.push_back(x);
    repeat (3) @(negedge clk);
    check("ocupado_mid_calc", 64'(bus.ocupado), 1);
    pulse_start(19'd500, 19'd500, 19'd9, k);
    bus.multiplicando = 19'd77;
    bus.multiplicador = 19'd88;
    bus.sumando       = 19'd99;
    wait_idle("busy_timeout");
    repeat (4) @(negedge clk);
    check("busy_single_listo", 64'(sb.size()), 0);

    // Reset 5 cycles into an operation: outputs cleared, no listo afterwards.
    pulse_start(19'd9, 19'd9, 19'd9, k);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_producto", 64'(bus.producto), 0);
    check("abort_desborde", 64'(bus.desborde), 0);
    check("abort_ocupado",  64'(bus.ocupado),  0);
    check("abort_listo",    64'(bus.listo),    0);
    rst = 1'b0;
    repeat (N + 4) @(negedge clk);
    run_op(19'd3, 19'd4, 19'd0, 19'd12, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
